// File: rtl/dsp_div_32.sv
// Signed 32/16 restoring divider with saturated 16-bit quotient; one result in flight.
// Latency: out_valid rises 34 edges after the accept edge; in_ready low until the result is taken.
module dsp_div_32 (
    input  logic        clock,
    input  logic        resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] X,
    input  logic [15:0] B,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] A,
    output logic [15:0] R,
    output logic        ovf,
    output logic        div_zero
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t      state, state_nxt;
    logic [31:0] q_mag;
    logic [16:0] rem;
    logic [15:0] b_mag;
    logic        x_neg;
    logic        q_neg;
    logic [5:0]  cnt;

    logic [16:0] trial;
    logic [16:0] diff;
    logic        take;
    logic [15:0] a_fix;
    logic [15:0] r_fix;
    logic        ovf_fix;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clock) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    // The terminal-count cycle of CALC (cnt == 32) performs no step and hands off to FIX.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid)       state_nxt = CALC;
            CALC: if (cnt == 6'd32)   state_nxt = FIX;
            FIX:                      state_nxt = DONE;
            DONE: if (out_ready)      state_nxt = IDLE;
            default:                  state_nxt = IDLE;
        endcase
    end

    // rem[16] is never set in practice (rem < b_mag <= 2^15) but is folded in for safety.
    always_comb begin
        trial = {rem[15:0], q_mag[31]};
        take  = rem[16] | (trial >= {1'b0, b_mag});
        diff  = trial - {1'b0, b_mag};
    end

    always_comb begin
        a_fix   = q_mag[15:0];
        r_fix   = x_neg ? (16'd0 - rem[15:0]) : rem[15:0];
        ovf_fix = 1'b0;
        if (b_mag == 16'd0) begin
            a_fix = x_neg ? 16'h8000 : 16'h7FFF;
            r_fix = 16'd0;
        end else if (!q_neg) begin
            if (q_mag > 32'd32767) begin
                a_fix   = 16'h7FFF;
                ovf_fix = 1'b1;
            end
        end else begin
            if (q_mag > 32'd32768) begin
                a_fix   = 16'h8000;
                ovf_fix = 1'b1;
            end else begin
                a_fix = 16'd0 - q_mag[15:0];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            q_mag    <= '0;
            rem      <= '0;
            b_mag    <= '0;
            x_neg    <= 1'b0;
            q_neg    <= 1'b0;
            cnt      <= '0;
            A        <= '0;
            R        <= '0;
            ovf      <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    // Negating 32'h80000000 yields itself, which reads correctly as 2^31 unsigned.
                    q_mag <= X[31] ? (32'd0 - X) : X;
                    b_mag <= B[15] ? (16'd0 - B) : B;
                    x_neg <= X[31];
                    q_neg <= X[31] ^ B[15];
                    rem   <= '0;
                    cnt   <= '0;
                end
                CALC: if (cnt != 6'd32) begin
                    rem   <= take ? diff : trial;
                    q_mag <= {q_mag[30:0], take};
                    cnt   <= cnt + 6'd1;
                end
                FIX: begin
                    A        <= a_fix;
                    R        <= r_fix;
                    ovf      <= ovf_fix;
                    div_zero <= (b_mag == 16'd0);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dsp_div_32.sv
// Directed bench for dsp_div_32: hand-computed quotient/remainder vectors, latency, backpressure, reset.
module tb_dsp_div_32;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] X = '0;
    logic [15:0] B = '0;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] A;
    logic [15:0] R;
    logic        ovf;
    logic        div_zero;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    dsp_div_32 dut (
        .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
        .X(X), .B(B), .out_valid(out_valid), .out_ready(out_ready),
        .A(A), .R(R), .ovf(ovf), .div_zero(div_zero)
    );

    // Offers a pair, then keeps in_valid high with junk during the computation; returns edges to out_valid or -1.
    task automatic do_div(input logic [31:0] x, input logic [15:0] b, output int lat);
        int w = 0;
        while (!in_ready && w < 50) begin
            @(posedge clock); #1; w++;
        end
        if (!in_ready) begin
            lat = -1;
            return;
        end
        in_valid = 1'b1; X = x; B = b;
        @(posedge clock); #1;
        X = ~x; B = ~b;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clock); #1; lat++;
        end
        in_valid = 1'b0;
        if (!out_valid) lat = -1;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0; in_valid = 1'b1; X = 32'd50; B = 16'd5;
        repeat (3) @(posedge clock);
        #1; resetn = 1'b1; in_valid = 1'b0;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (A !== 16'd0) begin failures++; $display("FAIL reset_A got=%h exp=0000", A); end
        checks++; if (R !== 16'd0) begin failures++; $display("FAIL reset_R got=%h exp=0000", R); end
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
        checks++; if (div_zero !== 1'b0) begin failures++; $display("FAIL reset_div_zero got=%b exp=0", div_zero); end
    endtask

    task automatic test_basic();
        int lat;
        do_div(32'h000186A0, 16'd7, lat);
        checks++; if (lat !== 34) begin failures++; $display("FAIL basic_latency got=%0d exp=34", lat); end
        checks++; if (A !== 16'd14285) begin failures++; $display("FAIL basic_A got=%0d exp=14285", A); end
        checks++; if (R !== 16'd5) begin failures++; $display("FAIL basic_R got=%0d exp=5", R); end
        checks++; if (ovf !== 1'b0 || div_zero !== 1'b0) begin failures++; $display("FAIL basic_flags got=%b%b exp=00", ovf, div_zero); end
        consume();
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL basic_handshake got=%b%b exp=10", in_ready, out_valid); end
        checks++; if (A !== 16'd14285 || R !== 16'd5) begin failures++; $display("FAIL basic_retain got=%h/%h exp=37cd/0005", A, R); end
    endtask

    task automatic test_signs();
        logic [31:0] xs [3] = '{32'hFFFFFF9C, 32'h00000064, 32'hFFFFFF9C};
        logic [15:0] bs [3] = '{16'h0007, 16'hFFF9, 16'hFFF9};
        logic [15:0] ae [3] = '{16'hFFF2, 16'hFFF2, 16'h000E};
        logic [15:0] re [3] = '{16'hFFFE, 16'h0002, 16'hFFFE};
        int lat;
        int ident;
        for (int i = 0; i < 3; i++) begin
            do_div(xs[i], bs[i], lat);
            checks++; if (lat !== 34) begin failures++; $display("FAIL sign%0d_latency got=%0d exp=34", i, lat); end
            checks++; if (A !== ae[i]) begin failures++; $display("FAIL sign%0d_A got=%h exp=%h", i, A, ae[i]); end
            checks++; if (R !== re[i]) begin failures++; $display("FAIL sign%0d_R got=%h exp=%h", i, R, re[i]); end
            ident = int'($signed(A)) * int'($signed(bs[i])) + int'($signed(R));
            checks++; if (ident !== int'($signed(xs[i]))) begin failures++; $display("FAIL sign%0d_identity got=%0d exp=%0d", i, ident, $signed(xs[i])); end
            consume();
        end
    endtask

    task automatic test_overflow();
        logic [31:0] xs [4] = '{32'h80000000, 32'h00010000, 32'hFFFF8000, 32'hFFFF0000};
        logic [15:0] bs [4] = '{16'hFFFF, 16'h0001, 16'h0001, 16'h0001};
        logic [15:0] ae [4] = '{16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000};
        logic        oe [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        int lat;
        for (int i = 0; i < 4; i++) begin
            do_div(xs[i], bs[i], lat);
            checks++; if (lat !== 34) begin failures++; $display("FAIL ovf%0d_latency got=%0d exp=34", i, lat); end
            checks++; if (A !== ae[i]) begin failures++; $display("FAIL ovf%0d_A got=%h exp=%h", i, A, ae[i]); end
            checks++; if (ovf !== oe[i]) begin failures++; $display("FAIL ovf%0d_ovf got=%b exp=%b", i, ovf, oe[i]); end
            checks++; if (R !== 16'd0 || div_zero !== 1'b0) begin failures++; $display("FAIL ovf%0d_R_dz got=%h/%b exp=0000/0", i, R, div_zero); end
            consume();
        end
    endtask

    task automatic test_div_zero();
        logic [31:0] xs [2] = '{32'hFFFFFFFB, 32'h00000000};
        logic [15:0] ae [2] = '{16'h8000, 16'h7FFF};
        int lat;
        for (int i = 0; i < 2; i++) begin
            do_div(xs[i], 16'h0000, lat);
            checks++; if (lat !== 34) begin failures++; $display("FAIL dz%0d_latency got=%0d exp=34", i, lat); end
            checks++; if (A !== ae[i]) begin failures++; $display("FAIL dz%0d_A got=%h exp=%h", i, A, ae[i]); end
            checks++; if (R !== 16'd0) begin failures++; $display("FAIL dz%0d_R got=%h exp=0000", i, R); end
            checks++; if (div_zero !== 1'b1 || ovf !== 1'b0) begin failures++; $display("FAIL dz%0d_flags got=dz%b ovf%b exp=dz1 ovf0", i, div_zero, ovf); end
            consume();
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        do_div(32'h000186A0, 16'd7, lat);
        checks++; if (lat !== 34) begin failures++; $display("FAIL bp_latency got=%0d exp=34", lat); end
        in_valid = 1'b1; X = 32'hFFFFFF9C; B = 16'h0007;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || A !== 16'd14285 || R !== 16'd5) begin
                failures++;
                $display("FAIL bp_hold%0d got=ov%b ir%b A=%h R=%h exp=ov1 ir0 A=37cd R=0005", i, out_valid, in_ready, A, R);
            end
        end
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL bp_release got=%b%b exp=10", in_ready, out_valid); end
        @(posedge clock); #1;
        X = 32'h12345678; B = 16'h0003;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_accept got=%b exp=0", in_ready); end
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clock); #1; lat++;
        end
        in_valid = 1'b0;
        checks++; if (lat !== 34) begin failures++; $display("FAIL bp_second_latency got=%0d exp=34", lat); end
        checks++; if (A !== 16'hFFF2 || R !== 16'hFFFE) begin failures++; $display("FAIL bp_second_result got=%h/%h exp=fff2/fffe", A, R); end
        consume();
    endtask

    task automatic test_mid_reset();
        int lat;
        int w = 0;
        while (!in_ready && w < 50) begin
            @(posedge clock); #1; w++;
        end
        in_valid = 1'b1; X = 32'h000186A0; B = 16'd7;
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clock);
        #1; resetn = 1'b0; in_valid = 1'b1;
        @(posedge clock); #1;
        resetn = 1'b1; in_valid = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL mrst_handshake got=%b%b exp=10", in_ready, out_valid); end
        checks++; if (A !== 16'd0 || R !== 16'd0 || ovf !== 1'b0 || div_zero !== 1'b0) begin
            failures++; $display("FAIL mrst_outputs got=%h/%h/%b/%b exp=0000/0000/0/0", A, R, ovf, div_zero);
        end
        do_div(32'd1000, 16'hFFFD, lat);
        checks++; if (lat !== 34) begin failures++; $display("FAIL mrst_latency got=%0d exp=34", lat); end
        checks++; if (A !== 16'hFEB3 || R !== 16'h0001) begin failures++; $display("FAIL mrst_result got=%h/%h exp=feb3/0001", A, R); end
        consume();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signs();
        test_overflow();
        test_div_zero();
        test_back_to_back();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dsp_div_32.md
DSP_DIV_32 -- requirements
Module: dsp_div_32

Interface
REQ-001 The module SHALL have no parameters; widths are fixed at 32-bit dividend, 16-bit divisor, 16-bit quotient and 16-bit remainder.
REQ-002 clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 resetn  input  1  synchronous, active-low reset; sampled on the rising edge of clock.
REQ-004 in_valid  input  1  dividend/divisor pair present.
REQ-005 in_ready  output  1  divider idle; the pair is accepted on an edge where in_valid && in_ready.
REQ-006 X  input  32  signed dividend, two's complement.
REQ-007 B  input  16  signed divisor, two's complement.
REQ-008 out_valid  output  1  result registers hold a valid result.
REQ-009 out_ready  input  1  consumer accepts the result; the result is consumed on an edge where out_valid && out_ready.
REQ-010 A  output  16  signed quotient, saturated.
REQ-011 R  output  16  signed remainder.
REQ-012 ovf  output  1  the true quotient is outside [-32768, 32767].
REQ-013 div_zero  output  1  B was 0.

Function
REQ-014 States SHALL be IDLE, CALC, FIX and DONE; in_ready=1 only in IDLE, and out_valid=1 only in DONE.
REQ-015 IDLE->CALC on accept: capture |X| as 32-bit unsigned, |B| as 16-bit unsigned, sign(X) and sign(X)^sign(B); clear the iteration counter.
REQ-016 CALC SHALL perform one restoring shift-subtract step per cycle, MSB first, for exactly 32 cycles, then go to FIX; the partial remainder is 17 bits wide and the magnitude quotient 32 bits.
REQ-017 FIX SHALL last one cycle: apply signs, saturate, and register A, R, ovf and div_zero; then go to DONE.
REQ-018 Latency: out_valid SHALL rise exactly 34 rising edges after the accept edge (the accept edge is edge 0, so the first cycle with out_valid=1 follows edge 34).
REQ-019 Quotient rounding: truncate toward zero; R SHALL carry the sign of X, or be 0; X == A*B + R whenever ovf=0 and div_zero=0.
REQ-020 Overflow: if the signed true quotient exceeds 32767, then A=16'h7FFF and ovf=1; if it is below -32768, then A=16'h8000 and ovf=1; R is still the true remainder.
REQ-021 Boundary: a quotient of exactly -32768 (e.g. X=-32768, B=1) SHALL give A=16'h8000 with ovf=0.
REQ-022 Divide by zero: when B=0, div_zero=1, ovf=0 and R=0; A=16'h7FFF if X>=0, otherwise A=16'h8000.
REQ-023 X=32'h80000000 SHALL be handled as magnitude 2^31 with no internal overflow.
REQ-024 DONE SHALL hold A, R, ovf, div_zero and out_valid stable until out_valid && out_ready, then go to IDLE; in_ready=1 on the following cycle.
REQ-025 in_valid SHALL be ignored in CALC, FIX and DONE, and X and B may change freely after the accept edge.
REQ-026 After consumption, A, R, ovf and div_zero SHALL retain their last values; only out_valid drops.

Reset
REQ-027 When resetn=0 at an edge, the state SHALL go to IDLE from any state, including mid-CALC or DONE.
REQ-028 Reset values: in_ready=1, out_valid=0, A=0, R=0, ovf=0, div_zero=0, iteration counter=0.
REQ-029 A pair offered with in_valid=1 on an edge where resetn=0 SHALL NOT be accepted.

Verification
REQ-030 X=32'h000186A0 (100000), B=7: A=14285, R=5, ovf=0, div_zero=0; out_valid rises exactly after edge 34, counting the accept edge as edge 0.
REQ-031 Sign combinations, each checking X == A*B + R:
  - X=-100, B=7 -> A=16'hFFF2 (-14), R=16'hFFFE (-2).
  - X=100, B=-7 -> A=-14, R=2.
  - X=-100, B=-7 -> A=14, R=-2.
REQ-032 Overflow and saturation boundaries:
  - X=32'h80000000, B=-1 -> A=16'h7FFF, ovf=1.
  - X=32'h00010000, B=1 -> A=16'h7FFF, ovf=1.
  - X=-32768, B=1 -> A=16'h8000, ovf=0.
REQ-033 Divide by zero:
  - X=-5, B=0 -> A=16'h8000, R=0, div_zero=1, ovf=0.
  - X=0, B=0 -> A=16'h7FFF, div_zero=1.
REQ-034 Backpressure: hold out_ready=0 for 10 cycles after out_valid rises while driving in_valid=1 with a new pair; outputs stay stable and in_ready stays 0; after out_ready=1 for one edge, in_ready=1 and the new pair is accepted and computed correctly.
REQ-035 Mid-operation reset: pull resetn low for one edge 10 cycles into CALC; next cycle in_ready=1 and out_valid=0 with all outputs 0; a following division X=1000, B=-3 yields A=-333, R=1.
